// File: rtl/wb_trace_pkg.sv
// rtl/wb_trace_pkg.sv - shared widths, trace entry type and width helper for writeback tracing
package wb_trace_pkg;

    localparam int REG_W         = 5;
    localparam int DATA_W        = 32;
    localparam int TRACE_CYCLE_W = 16;

    typedef struct packed {
        logic [TRACE_CYCLE_W-1:0] cycle;
        logic [REG_W-1:0]         rd;
        logic [DATA_W-1:0]        data;
    } trace_entry_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - circular-buffer FIFO exposing a look-ahead of the head after this edge
module trace_fifo
    import wb_trace_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    localparam int PTR_W = clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     push_data,
    output logic             full,
    output logic [LVL_W-1:0] level,
    output logic             next_valid,
    output logic [W-1:0]     next_head
);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr_nx;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] after_pop;
    logic             do_push;
    logic             do_pop;

    assign full      = (level_q == LVL_W'(DEPTH));
    assign level     = level_q;
    assign do_pop    = pop & (level_q != '0);
    assign do_push   = push & (~full | do_pop);
    assign rd_ptr_nx = rd_ptr + PTR_W'(do_pop);
    assign after_pop = level_q - LVL_W'(do_pop);

    // When the FIFO drains to nothing this edge, a concurrent push becomes the new head directly.
    assign next_valid = ~flush & ((after_pop != '0) | do_push);
    assign next_head  = (after_pop == '0) ? push_data : mem[rd_ptr_nx];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr  <= rd_ptr_nx;
            level_q <= after_pop + LVL_W'(do_push);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/wb_trace_capture.sv
// rtl/wb_trace_capture.sv - timestamps regfile writebacks and queues them on a valid/ready trace port
module wb_trace_capture
    import wb_trace_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int CYCLE_W = TRACE_CYCLE_W,
    parameter int DROP_W  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  capture_en,
    input  logic                  flush,
    input  logic                  ctrl_writeEnable,
    input  logic [REG_W-1:0]      ctrl_writeReg,
    input  logic [DATA_W-1:0]     data_writeReg,
    output logic                  trace_valid,
    input  logic                  trace_ready,
    output logic [CYCLE_W-1:0]    trace_cycle,
    output logic [REG_W-1:0]      trace_rd,
    output logic [DATA_W-1:0]     trace_data,
    output logic [clog2(DEPTH):0] level,
    output logic                  overflow,
    output logic [DROP_W-1:0]     drop_count
);

    logic [CYCLE_W-1:0] cycle_cnt;
    logic               push_req;
    logic               pop;
    logic               accept;
    logic               drop;
    logic               fifo_full;
    logic               next_valid;
    trace_entry_t       push_entry;
    trace_entry_t       next_head;
    trace_entry_t       head_q;

    // Writes to r0 are architecturally invisible and never traced.
    assign push_req   = capture_en & ctrl_writeEnable & (ctrl_writeReg != '0);
    assign pop        = trace_valid & trace_ready;
    assign accept     = push_req & ~flush;
    assign drop       = accept & fifo_full & ~pop;
    assign push_entry = '{cycle: TRACE_CYCLE_W'(cycle_cnt), rd: ctrl_writeReg, data: data_writeReg};

    trace_fifo #(
        .W     ($bits(trace_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .push       (accept),
        .pop        (pop),
        .push_data  (push_entry),
        .full       (fifo_full),
        .level      (level),
        .next_valid (next_valid),
        .next_head  (next_head)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_cnt   <= '0;
            overflow    <= 1'b0;
            drop_count  <= '0;
            trace_valid <= 1'b0;
            head_q      <= '0;
        end else begin
            cycle_cnt   <= cycle_cnt + CYCLE_W'(1);
            trace_valid <= next_valid;
            if (next_valid) begin
                head_q <= next_head;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) begin
                    drop_count <= drop_count + DROP_W'(1);
                end
            end
        end
    end

    assign trace_cycle = head_q.cycle[CYCLE_W-1:0];
    assign trace_rd    = head_q.rd;
    assign trace_data  = head_q.data;

endmodule

// File: tb/tb_wb_trace_capture.sv
// tb/tb_wb_trace_capture.sv - self-checking bench for wb_trace_capture against a queue model
module tb_wb_trace_capture;

    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        capture_en = 1'b0;
    logic        flush = 1'b0;
    logic        ctrl_writeEnable = 1'b0;
    logic [4:0]  ctrl_writeReg = '0;
    logic [31:0] data_writeReg = '0;
    logic        trace_ready = 1'b0;
    logic        trace_valid;
    logic [15:0] trace_cycle;
    logic [4:0]  trace_rd;
    logic [31:0] trace_data;
    logic [4:0]  level;
    logic        overflow;
    logic [7:0]  drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [15:0] cyc;
        logic [4:0]  rd;
        logic [31:0] data;
    } ment_t;

    ment_t       mq[$];
    int unsigned m_cnt   = 0;
    int unsigned m_drops = 0;
    logic        m_pop;
    logic        m_push;

    wb_trace_capture #(.DEPTH(DEPTH), .CYCLE_W(16), .DROP_W(8)) dut (
        .clock            (clock),
        .reset            (reset),
        .capture_en       (capture_en),
        .flush            (flush),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .trace_valid      (trace_valid),
        .trace_ready      (trace_ready),
        .trace_cycle      (trace_cycle),
        .trace_rd         (trace_rd),
        .trace_data       (trace_data),
        .level            (level),
        .overflow         (overflow),
        .drop_count       (drop_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: an ordered queue of captured writes, bounded at DEPTH, plus a drop tally.
    initial forever begin
        @(posedge clock);
        if (!reset) begin
            mq.delete();
            m_cnt   = 0;
            m_drops = 0;
        end else begin
            m_pop  = (mq.size() != 0) && trace_ready;
            m_push = capture_en && ctrl_writeEnable && (ctrl_writeReg != 5'd0);
            if (flush) begin
                mq.delete();
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_push) begin
                    if (mq.size() < DEPTH)
                        mq.push_back('{cyc: m_cnt[15:0], rd: ctrl_writeReg, data: data_writeReg});
                    else
                        m_drops++;
                end
            end
            m_cnt = (m_cnt + 1) % 65536;
        end
    end

    initial forever begin
        @(negedge clock);
        if (!reset) begin
            check("rst_valid", trace_valid, 0);
            check("rst_level", level, 0);
            check("rst_overflow", overflow, 0);
            check("rst_drop_count", drop_count, 0);
            check("rst_head", {trace_cycle, trace_rd, trace_data}, 0);
        end else begin
            check("valid", trace_valid, mq.size() != 0);
            check("level", level, mq.size());
            check("overflow", overflow, m_drops != 0);
            check("drop_count", drop_count, (m_drops > 255) ? 255 : m_drops);
            if (mq.size() != 0) begin
                check("head_cycle", trace_cycle, mq[0].cyc);
                check("head_rd", trace_rd, mq[0].rd);
                check("head_data", trace_data, mq[0].data);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic wr(input logic [4:0] rd, input logic [31:0] d);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = rd;
        data_writeReg    = d;
        step();
    endtask

    task automatic idle();
        ctrl_writeEnable = 1'b0;
        step();
    endtask

    initial begin
        step();
        step();
        check("lit_reset_valid", trace_valid, 0);
        check("lit_reset_level", level, 0);
        check("lit_reset_drop", drop_count, 0);
        check("lit_reset_cycle", trace_cycle, 0);

        // Basic capture and filtering; the cycle numbers below match the counter value.
        reset = 1'b1;
        capture_en = 1'b1;
        trace_ready = 1'b1;
        idle();
        idle();
        wr(5'd0, 32'd99);
        wr(5'd1, 32'd5);
        check("lit_basic1", {trace_valid, trace_cycle, trace_rd, trace_data}, {1'b1, 16'd3, 5'd1, 32'd5});
        wr(5'd2, 32'hFFFF_FFF9);
        check("lit_basic2", {trace_valid, trace_cycle, trace_rd, trace_data}, {1'b1, 16'd4, 5'd2, 32'hFFFF_FFF9});
        idle();
        check("lit_basic_drained", {trace_valid, level}, {1'b0, 5'd0});
        capture_en = 1'b0;
        wr(5'd5, 32'd1);
        capture_en = 1'b1;
        idle();
        check("lit_filter", {trace_valid, level, drop_count}, {1'b0, 5'd0, 8'd0});

        // Overflow: 20 writes into 16 entries, first one at cycle 8.
        trace_ready = 1'b0;
        for (int i = 1; i <= 20; i++) wr(5'(i), 32'h1000 + i);
        ctrl_writeEnable = 1'b0;
        check("lit_ovf_state", {level, overflow, drop_count}, {5'd16, 1'b1, 8'd4});
        check("lit_ovf_head", {trace_cycle, trace_rd}, {16'd8, 5'd1});

        // Full with simultaneous pop and push: r1 leaves, r21 joins at the tail.
        trace_ready = 1'b1;
        wr(5'd21, 32'hABCD);
        check("lit_fullpp", {level, drop_count, trace_rd, trace_cycle}, {5'd16, 8'd4, 5'd2, 16'd9});
        for (int k = 0; k < 16; k++) begin
            check("lit_drain_rd", trace_rd, (k < 15) ? k + 2 : 21);
            check("lit_drain_cycle", trace_cycle, (k < 15) ? 9 + k : 28);
            idle();
        end
        check("lit_drain_empty", {trace_valid, level}, {1'b0, 5'd0});

        // Flush with a concurrent write: nothing survives, nothing counted as dropped.
        trace_ready = 1'b0;
        for (int i = 1; i <= 10; i++) wr(5'(i), 32'h2000 + i);
        check("lit_flush_pre", level, 10);
        flush = 1'b1;
        wr(5'd11, 32'h2011);
        flush = 1'b0;
        check("lit_flush_post", {trace_valid, level, overflow, drop_count}, {1'b0, 5'd0, 1'b1, 8'd4});
        idle();
        check("lit_flush_stays", level, 0);

        // Counter wrap.
        for (int g = 0; g < 70000 && m_cnt != 65535; g++) idle();
        check("reach_65535", m_cnt, 65535);
        wr(5'd3, 32'h111);
        wr(5'd4, 32'h222);
        ctrl_writeEnable = 1'b0;
        check("lit_wrap1", {level, trace_cycle, trace_rd, trace_data}, {5'd2, 16'hFFFF, 5'd3, 32'h111});
        trace_ready = 1'b1;
        idle();
        check("lit_wrap2", {trace_cycle, trace_rd, trace_data}, {16'd0, 5'd4, 32'h222});
        idle();
        trace_ready = 1'b0;
        check("lit_wrap_empty", level, 0);

        // Asynchronous reset between edges with entries queued.
        for (int i = 1; i <= 5; i++) wr(5'(i + 8), 32'h3000 + i);
        ctrl_writeEnable = 1'b0;
        check("lit_async_pre", level, 5);
        #1 reset = 1'b0;
        #1;
        check("lit_async_now", {trace_valid, level, overflow, drop_count}, {1'b0, 5'd0, 1'b0, 8'd0});
        check("lit_async_head", {trace_cycle, trace_rd, trace_data}, 53'd0);
        step();
        step();
        reset = 1'b1;
        wr(5'd7, 32'h77);
        check("lit_after_rst", {trace_valid, trace_cycle, trace_rd, trace_data}, {1'b1, 16'd0, 5'd7, 32'h77});
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_trace_capture.md
Name: wb_trace_capture

Overview:
- Sits directly downstream of the processor/regfile writeback port, on the same ctrl_writeEnable / ctrl_writeReg / data_writeReg nets the regfile consumes.
- Timestamps every architecturally visible register write (rd != 0) with a free-running cycle count and buffers it in a FIFO.
- Drains entries through a valid/ready port to the test harness or a trace UART, so write-back logs are produced in hardware rather than by bench $fdisplay.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2
CYCLE_W, 16, timestamp width; counter wraps modulo 2^CYCLE_W
DROP_W, 8, dropped-entry counter width; saturating

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low; clears all state while 0
capture_en  in  1  1 = record writes (harness drives 0 in testing mode)
flush  in  1  synchronous clear of FIFO contents; counters untouched
ctrl_writeEnable  in  1  regfile write enable from processor
ctrl_writeReg  in  5  destination register
data_writeReg  in  32  write data
trace_valid  out  1  head entry available
trace_ready  in  1  consumer accepts head entry this cycle
trace_cycle  out  CYCLE_W  timestamp of head entry
trace_rd  out  5  register of head entry
trace_data  out  32  data of head entry
level  out  log2(DEPTH)+1  current occupancy
overflow  out  1  sticky: at least one write was dropped
drop_count  out  DROP_W  number of dropped writes, saturates at all-ones

Behaviour:
- Reset (reset=0, async): cycle counter=0, FIFO empty, trace_valid=0, trace_cycle/rd/data=0, level=0, overflow=0, drop_count=0.
- Cycle counter: increments every rising edge after reset release; the first edge after release samples with value 0. Wraps 2^CYCLE_W-1 -> 0. Runs regardless of capture_en and flush.
- Capture qualifier: push_req = capture_en & ctrl_writeEnable & (ctrl_writeReg != 0), sampled on the rising edge. The entry holds the counter value as of that edge, matching the bench "Cycle N" numbering.
- Pop: pop = trace_valid & trace_ready.
- Head outputs: registered FIFO-head view. An entry pushed into an empty FIFO appears on trace_valid one cycle after its capture edge (latency 1, no combinational bypass).
- Head stability: trace_cycle/rd/data hold stable while trace_valid=1 and trace_ready=0. They hold their last value when empty.
- Full, no pop: push_req is dropped, overflow<=1, drop_count increments (saturating). FIFO contents are unchanged.
- Full with simultaneous pop: push is accepted, level stays DEPTH, no drop.
- Empty with trace_ready=1: no effect.
- Simultaneous push and pop, non-full: both occur, level unchanged.
- Pointers: DEPTH-entry circular buffer with wrapping read/write pointers. Full/empty come from level, not pointer equality alone.
- flush=1: pointers and level return to 0 and trace_valid<=0 on that edge. A push_req in the same cycle is discarded and is not counted as a drop. overflow and drop_count are cleared only by reset.
- capture_en=0: no pushes; draining continues normally.
- Reset mid-operation: all entries are lost immediately (async). No X on outputs after release.

Decomposition:
- Package wb_trace_pkg holds:
  - constants REG_W=5 and DATA_W=32
  - the entry struct {cycle, rd, data}
  - the helper function clog2 for level width
- One sub-module, trace_fifo: generic synchronous FIFO (entry-width parameter, DEPTH, push/pop, full/empty, level, flush) holding storage and pointers.
- wb_trace_capture keeps in its top level the qualifier, cycle counter, drop accounting and output registers.

Test Plan:
- Basic capture: after reset release, writes at cycles 3 (r1=5) and 4 (r2=-7) with trace_ready=1 -> trace_valid at cycles 4 and 5 with {3,1,5} then {4,2,0xFFFFFFF9}; level returns to 0.
- Filtering: write to r0=99 at cycle 2, and r5=1 with capture_en=0 -> no entry, level stays 0, drop_count=0.
- Overflow: trace_ready=0, 20 consecutive writes r1..r20 (DEPTH=16) -> level=16, overflow=1, drop_count=4. Draining yields r1..r16 in order with consecutive timestamps.
- Full with simultaneous push and pop: FIFO full, trace_ready=1, one write in the same cycle -> no drop, level remains 16, newest entry appears last.
- Flush and wrap: fill 10 entries, assert flush with a concurrent write -> level=0, trace_valid=0, drop_count unchanged. Then run past cycle 65535 (CYCLE_W=16) -> a write at count 65535 followed by one at 0 is timestamped 65535 then 0.
- Async reset mid-stream: assert reset=0 between edges with 5 entries queued -> outputs clear immediately without waiting for a clock edge. After release, the first capture is stamped at cycle 0.
